// File: rtl/hlsm_shared_mul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hlsm_pkg
// Shared types for the resource-constrained HLSM controller computing
// j = (a*b + c)*d and k = e*f through one shared pipelined multiplier.
//   state_t   : controller FSM states
//   mul_tag_t : sideband tag travelling with each product through the multiplier
//   HLSM_DATAW: default operand/result width
// -----------------------------------------------------------------------------
package hlsm_pkg;

   localparam int HLSM_DATAW = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_AB = 3'd1,
      ISSUE_EF = 3'd2,
      WAIT_H   = 3'd3,
      ADD      = 3'd4,
      ISSUE_ID = 3'd5,
      WAIT_J   = 3'd6,
      DONE     = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      T_NONE = 2'd0,
      T_AB   = 2'd1,
      T_EF   = 2'd2,
      T_ID   = 2'd3
   } mul_tag_t;

endpackage

// File: rtl/hlsm_shared_mul_ctrl_mul_pipe.sv
// -----------------------------------------------------------------------------
// hlsm_mul_pipe
// Shared signed multiplier followed by a MUL_LAT-deep register chain. Each
// issue carries a tag; the product, its tag and a valid bit emerge exactly
// MUL_LAT cycles after issue. Products wrap to DATAW bits.
// Ports:
//   Clk, Rst               clock, synchronous active-high reset (clears valids)
//   issue_valid, issue_tag issue strobe and tag for the operands x, y
//   x, y                   DATAW-bit signed operands
//   res_valid, res_tag     result strobe and tag, MUL_LAT cycles after issue
//   res                    low DATAW bits of the signed product
// -----------------------------------------------------------------------------
module hlsm_mul_pipe
   import hlsm_pkg::*;
#(
   parameter int DATAW   = HLSM_DATAW,
   parameter int MUL_LAT = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             issue_valid,
   input  logic [1:0]       issue_tag,
   input  logic [DATAW-1:0] x,
   input  logic [DATAW-1:0] y,
   output logic             res_valid,
   output logic [1:0]       res_tag,
   output logic [DATAW-1:0] res
);

   logic [DATAW-1:0] prod_s;
   logic [DATAW-1:0] prod_r [MUL_LAT];
   logic [1:0]       tag_r  [MUL_LAT];
   logic             vld_r  [MUL_LAT];

   // Low DATAW bits of a two's-complement product do not depend on operand
   // signedness, so a DATAW-wide multiply gives the wrapped signed result.
   always_comb begin
      prod_s = x * y;
   end

   // Product/tag/valid delay chain; reset drops everything in flight.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int s = 0; s < MUL_LAT; s++) begin
            prod_r[s] <= {DATAW{1'b0}};
            tag_r[s]  <= T_NONE;
            vld_r[s]  <= 1'b0;
         end
      end else begin
         prod_r[0] <= prod_s;
         tag_r[0]  <= issue_valid ? issue_tag : T_NONE;
         vld_r[0]  <= issue_valid;
         for (int s = 1; s < MUL_LAT; s++) begin
            prod_r[s] <= prod_r[s-1];
            tag_r[s]  <= tag_r[s-1];
            vld_r[s]  <= vld_r[s-1];
         end
      end
   end

   assign res_valid = vld_r[MUL_LAT-1];
   assign res_tag   = tag_r[MUL_LAT-1];
   assign res       = prod_r[MUL_LAT-1];

endmodule

// File: rtl/hlsm_shared_mul_ctrl.sv
// -----------------------------------------------------------------------------
// hlsm_shared_mul_ctrl
// Computes j = (a*b + c)*d and k = e*f using one shared pipelined multiplier
// and one adder. Multiplications are issued in the order a*b, e*f, i*d and the
// returned products are routed by tag.
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   Start         launch request, honoured only while idle
//   a..f          DATAW-bit signed operands, captured when Start is accepted
//   j, k          results, held after Done until the next accepted Start
//   Done          one-cycle completion pulse
//   Busy          high from the cycle after acceptance through the Done cycle
// -----------------------------------------------------------------------------
module hlsm_shared_mul_ctrl
   import hlsm_pkg::*;
#(
   parameter int DATAW   = HLSM_DATAW,
   parameter int MUL_LAT = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [DATAW-1:0] a,
   input  logic [DATAW-1:0] b,
   input  logic [DATAW-1:0] c,
   input  logic [DATAW-1:0] d,
   input  logic [DATAW-1:0] e,
   input  logic [DATAW-1:0] f,
   output logic [DATAW-1:0] j,
   output logic [DATAW-1:0] k,
   output logic             Done,
   output logic             Busy
);

   state_t           state_r;
   logic [DATAW-1:0] a_r, b_r, c_r, d_r, e_r, f_r;
   logic [DATAW-1:0] h_r, i_r;

   logic             issue_valid_s;
   logic [1:0]       issue_tag_s;
   logic [DATAW-1:0] x_s, y_s;
   logic             res_valid_s;
   logic [1:0]       res_tag_s;
   logic [DATAW-1:0] res_s;

   // Operand steering into the shared multiplier, decoded from the state.
   always_comb begin
      issue_valid_s = 1'b0;
      issue_tag_s   = T_NONE;
      x_s           = {DATAW{1'b0}};
      y_s           = {DATAW{1'b0}};
      case (state_r)
         ISSUE_AB: begin
            issue_valid_s = 1'b1;
            issue_tag_s   = T_AB;
            x_s           = a_r;
            y_s           = b_r;
         end
         ISSUE_EF: begin
            issue_valid_s = 1'b1;
            issue_tag_s   = T_EF;
            x_s           = e_r;
            y_s           = f_r;
         end
         ISSUE_ID: begin
            issue_valid_s = 1'b1;
            issue_tag_s   = T_ID;
            x_s           = i_r;
            y_s           = d_r;
         end
         default: begin
            issue_valid_s = 1'b0;
         end
      endcase
   end

   hlsm_mul_pipe #(
      .DATAW   (DATAW),
      .MUL_LAT (MUL_LAT)
   ) u_mul (
      .Clk         (Clk),
      .Rst         (Rst),
      .issue_valid (issue_valid_s),
      .issue_tag   (issue_tag_s),
      .x           (x_s),
      .y           (y_s),
      .res_valid   (res_valid_s),
      .res_tag     (res_tag_s),
      .res         (res_s)
   );

   // Controller FSM with operand capture, adder and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= IDLE;
         a_r     <= {DATAW{1'b0}};
         b_r     <= {DATAW{1'b0}};
         c_r     <= {DATAW{1'b0}};
         d_r     <= {DATAW{1'b0}};
         e_r     <= {DATAW{1'b0}};
         f_r     <= {DATAW{1'b0}};
         h_r     <= {DATAW{1'b0}};
         i_r     <= {DATAW{1'b0}};
         j       <= {DATAW{1'b0}};
         k       <= {DATAW{1'b0}};
         Done    <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         // e*f lands while the FSM is elsewhere, so k is captured by tag alone.
         if (res_valid_s && (res_tag_s == T_EF)) begin
            k <= res_s;
         end

         case (state_r)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  a_r     <= a;
                  b_r     <= b;
                  c_r     <= c;
                  d_r     <= d;
                  e_r     <= e;
                  f_r     <= f;
                  j       <= {DATAW{1'b0}};
                  k       <= {DATAW{1'b0}};
                  Busy    <= 1'b1;
                  state_r <= ISSUE_AB;
               end else begin
                  Busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            ISSUE_AB: begin
               state_r <= ISSUE_EF;
            end
            ISSUE_EF: begin
               // With a one-cycle multiplier a*b is already back here.
               if (res_valid_s && (res_tag_s == T_AB)) begin
                  h_r     <= res_s;
                  state_r <= ADD;
               end else begin
                  state_r <= WAIT_H;
               end
            end
            WAIT_H: begin
               if (res_valid_s && (res_tag_s == T_AB)) begin
                  h_r     <= res_s;
                  state_r <= ADD;
               end else begin
                  state_r <= WAIT_H;
               end
            end
            ADD: begin
               i_r     <= h_r + c_r;
               state_r <= ISSUE_ID;
            end
            ISSUE_ID: begin
               state_r <= WAIT_J;
            end
            WAIT_J: begin
               if (res_valid_s && (res_tag_s == T_ID)) begin
                  j       <= res_s;
                  Done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= WAIT_J;
               end
            end
            DONE: begin
               Done    <= 1'b0;
               Busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               Done    <= 1'b0;
               Busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/hlsm_shared_mul_ctrl.md
Name: hlsm_shared_mul_ctrl

Overview:
- Resource-constrained controller for the HLS benchmark dataflow: j = (a*b + c)*d and k = e*f.
- Owns one shared pipelined multiplier and one adder, and time-multiplexes the three multiplications through that multiplier.
- Sequences operand issue, routes returned products by tag, and presents a Start/Done handshake.
- Drop-in alternative to the latency-scheduled HLSM wherever multiplier area matters more than latency.

Parameters:
- DATAW, 16, operand/result width (signed two's complement).
- MUL_LAT, 2, shared multiplier pipeline latency in cycles (>=1).

Ports:
- Clk  input  1  clock, all state on rising edge
- Rst  input  1  synchronous active-high reset
- Start  input  1  launch request, sampled only in IDLE
- a, b, c, d, e, f  input  DATAW  signed operands, captured in the cycle Start is accepted
- j  output  DATAW  signed result (a*b+c)*d
- k  output  DATAW  signed result e*f
- Done  output  1  one-cycle completion pulse
- Busy  output  1  high from the cycle after Start is accepted through the Done cycle

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Reset values:
  - state=IDLE; j=k=0; Done=0; Busy=0.
  - Internal h, i and captured operands = 0.
  - All multiplier pipeline valid bits = 0.
- Arithmetic:
  - Products are the low DATAW bits of the signed full product (wrap).
  - Add wraps modulo 2^DATAW.
  - No saturation and no overflow flag.
- Multiplier:
  - Accepts at most one issue per cycle (issue_valid, tag, x, y).
  - Result and tag appear with res_valid exactly MUL_LAT cycles after issue.
  - Tags: T_AB, T_EF, T_ID.
- States and transitions (cycle 0 = cycle Start=1 seen in IDLE):
  - IDLE: on Start, capture a..f, clear j, k, Done, and go to ISSUE_AB. Otherwise stay.
  - ISSUE_AB (cycle 1): issue a*b tag T_AB, then go to ISSUE_EF.
  - ISSUE_EF (cycle 2): issue e*f tag T_EF, then go to WAIT_H.
  - WAIT_H: on res_valid with T_AB, h <= product and go to ADD. With MUL_LAT=1 the T_AB result arrives in cycle 2 (ISSUE_EF) and is captured there, so ISSUE_EF goes directly to ADD.
  - ADD (cycle 2+MUL_LAT): i <= h + c, then go to ISSUE_ID.
  - ISSUE_ID (cycle 3+MUL_LAT): issue i*d tag T_ID, then go to WAIT_J.
  - WAIT_J: on res_valid with T_ID, j <= product and go to DONE.
  - DONE (cycle 4+2*MUL_LAT): Done=1 for exactly this cycle, Busy=1, then go to IDLE.
- k capture: k <= product whenever res_valid with T_EF arrives (cycle 2+MUL_LAT), independent of state.
- Result hold: j and k hold their values after Done until the next accepted Start.
- Start while not in IDLE: ignored, with no queuing.
- Start held high continuously: a new run is accepted in the IDLE cycle after DONE, giving a period of 5+2*MUL_LAT cycles.
- Reset mid-operation: next cycle is IDLE with outputs zeroed and all in-flight products discarded. No Done pulse from the aborted run.
- Unexpected tag in WAIT_H/WAIT_J (cannot occur by construction): ignored; the bench asserts it never happens.
- default state: go to IDLE.

Decomposition:
- Shared package hlsm_pkg holds:
  - state enum (IDLE, ISSUE_AB, ISSUE_EF, WAIT_H, ADD, ISSUE_ID, WAIT_J, DONE);
  - mul tag enum (T_NONE, T_AB, T_EF, T_ID);
  - DATAW default constant.
- One sub-module, hlsm_mul_pipe:
  - parameterised DATAW and MUL_LAT;
  - signed multiply feeding a MUL_LAT-deep register chain with valid+tag sideband;
  - synchronous Rst clears all valids.
- Controller FSM, operand registers and adder live in the top.

Test Plan:
- Nominal, MUL_LAT=2: a=3, b=4, c=5, d=2, e=-6, f=7, Start pulse at cycle 0 -> Done=1 only in cycle 8; j=34, k=-42; Busy=1 over cycles 1..8.
- Wrap: a=300, b=300, c=0, d=1, e=256, f=256 -> j=24464 (90000 mod 65536), k=0; negatives a=-2, b=3, c=1, d=-4 -> j=20.
- Start ignored while busy: second Start at cycle 3 with different operands -> single Done at cycle 8, results from the first operands only, no second Done.
- Reset mid-op: Rst=1 in cycle 4 -> cycle 5 IDLE, j=k=0, Busy=0, no Done for 20 cycles; a fresh Start then gives correct results.
- Back-to-back: Start held high, operand sets A then B -> Done pulses at cycles 8 and 17; j/k match A after the first pulse and B after the second.
- MUL_LAT=1 build: nominal operands -> Done at cycle 6, j=34, k=-42.
